// File: rtl/led_pattern_pkg.sv
// Shared definitions for the rotating LED pattern generator and its checker.
package led_pattern_pkg;

  localparam int WIDTH = 12;
  localparam logic [WIDTH-1:0] BASE_LED_SEQUENCE = 12'b000011101101;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // Rotate left by n positions (n taken modulo WIDTH).
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int unsigned n);
    logic [2*WIDTH-1:0] dbl;
    int unsigned        s;
    dbl = {v, v};
    s   = n % WIDTH;
    return dbl[(2*WIDTH-1)-s -: WIDTH];
  endfunction

endpackage

// File: rtl/led_rot_decode.sv
// Combinational decoder: finds which rotation of the base pattern the LED word is.
module led_rot_decode
  import led_pattern_pkg::*;
#(
  parameter int             W    = led_pattern_pkg::WIDTH,
  parameter logic [W-1:0]   BASE = led_pattern_pkg::BASE_LED_SEQUENCE
) (
  input  logic [W-1:0] led_i,
  output logic         hit_o,
  output logic [3:0]   k_o
);

  // Doubling the base lets every rotation be a fixed part-select.
  localparam logic [2*W-1:0] BASE_DBL = {BASE, BASE};

  logic [W-1:0] match;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_rot
      assign match[gi] = (led_i == BASE_DBL[(2*W-1)-gi -: W]);
    end
  endgenerate

  // Priority pick: scanning downward leaves the lowest matching rotation in k_o.
  always_comb begin
    hit_o = |match;
    k_o   = 4'd0;
    for (int i = W - 1; i >= 0; i--) begin
      if (match[i]) k_o = 4'(i);
    end
  end

endmodule

// File: rtl/led_pattern_checker.sv
// LED bus monitor: decodes the rotation phase, locks onto the advancing
// sequence and flags/counts out-of-sequence words while locked.
module led_pattern_checker
  import led_pattern_pkg::*;
#(
  parameter int                 WIDTH             = led_pattern_pkg::WIDTH,
  parameter logic [WIDTH-1:0]   BASE_LED_SEQUENCE = led_pattern_pkg::BASE_LED_SEQUENCE,
  parameter int                 LOCK_MATCHES      = 3,
  parameter int                 UNLOCK_ERRORS     = 2,
  parameter int                 ERR_CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 led_valid,
  input  logic [WIDTH-1:0]     led,
  output logic [3:0]           phase,
  output logic                 phase_valid,
  output logic                 locked,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int MCW = $clog2(LOCK_MATCHES + 1);
  localparam int ERW = $clog2(UNLOCK_ERRORS + 1);
  localparam logic [3:0] LAST_PHASE = 4'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] BASE_DBL = {BASE_LED_SEQUENCE, BASE_LED_SEQUENCE};

  state_e                 state_q;
  logic [3:0]             exp_phase_q;
  logic [MCW-1:0]         match_cnt_q;
  logic [ERW-1:0]         err_run_q;
  logic [3:0]             phase_q;
  logic                   phase_valid_q;
  logic                   mismatch_q;
  logic [ERR_CNT_W-1:0]   err_count_q;

  logic                   dec_hit;
  logic [3:0]             dec_k;
  logic [WIDTH-1:0]       exp_word;
  logic                   in_seq;
  logic [3:0]             exp_phase_d;
  logic [3:0]             hit_phase_d;
  logic [ERR_CNT_W-1:0]   err_count_d;

  function automatic logic [3:0] phase_inc(input logic [3:0] p);
    return (p == LAST_PHASE) ? 4'd0 : p + 4'd1;
  endfunction

  led_rot_decode #(
    .W    (WIDTH),
    .BASE (BASE_LED_SEQUENCE)
  ) u_decode (
    .led_i (led),
    .hit_o (dec_hit),
    .k_o   (dec_k)
  );

  // Expected word for the tracked phase, and the next-phase / counter helpers.
  always_comb begin
    exp_word    = BASE_DBL[(2*WIDTH-1) - int'(exp_phase_q) -: WIDTH];
    in_seq      = (led == exp_word);
    exp_phase_d = phase_inc(exp_phase_q);
    hit_phase_d = phase_inc(dec_k);
    err_count_d = (&err_count_q) ? err_count_q : err_count_q + ERR_CNT_W'(1);
  end

  // Tracker FSM with all outputs registered; state only moves on valid samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      exp_phase_q   <= 4'd0;
      match_cnt_q   <= '0;
      err_run_q     <= '0;
      phase_q       <= 4'd0;
      phase_valid_q <= 1'b0;
      mismatch_q    <= 1'b0;
      err_count_q   <= '0;
    end else if (!led_valid) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q    <= 1'b0;
      phase_valid_q <= dec_hit;
      if (dec_hit) phase_q <= dec_k;

      case (state_q)
        SEARCH: begin
          if (dec_hit) begin
            exp_phase_q <= hit_phase_d;
            match_cnt_q <= MCW'(1);
            err_run_q   <= '0;
            state_q     <= (LOCK_MATCHES == 1) ? LOCKED : LOCKING;
          end
        end

        LOCKING: begin
          if (in_seq) begin
            exp_phase_q <= exp_phase_d;
            if (match_cnt_q == MCW'(LOCK_MATCHES - 1)) begin
              state_q   <= LOCKED;
              err_run_q <= '0;
            end else begin
              match_cnt_q <= match_cnt_q + MCW'(1);
            end
          end else if (dec_hit) begin
            // Different phase but a legal word: start counting again from it.
            exp_phase_q <= hit_phase_d;
            match_cnt_q <= MCW'(1);
          end else begin
            state_q     <= SEARCH;
            match_cnt_q <= '0;
          end
        end

        LOCKED: begin
          // Flywheel: the expected phase keeps advancing even through errors.
          exp_phase_q <= exp_phase_d;
          if (in_seq) begin
            err_run_q <= '0;
          end else begin
            mismatch_q  <= 1'b1;
            err_count_q <= err_count_d;
            if (err_run_q == ERW'(UNLOCK_ERRORS - 1)) begin
              state_q     <= SEARCH;
              err_run_q   <= '0;
              match_cnt_q <= '0;
            end else begin
              err_run_q <= err_run_q + ERW'(1);
            end
          end
        end

        default: begin
          state_q <= SEARCH;
        end
      endcase
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign locked      = (state_q == LOCKED);
  assign mismatch    = mismatch_q;
  assign err_count   = err_count_q;

endmodule
